ftb_update_ctrl: RTL and testbench
==================================

Name: ftb_update_ctrl

Overview:
- Sequences all writes into the FTB: arbitrates two update requesters (backend commit, frontend predecode fix) onto the single FTB update path.
- Each update is a read-modify-write: read the set, detect tag hit, merge the 2-bit counter, pick a victim way on miss, write back.
- Sits between the FTQ/backend and the FTB SRAM wrapper. It shares the FTB read port with the predictor, which always has priority.

Parameters:
- FTB_SETS, 512, number of FTB sets (power of 2); IDX_W = log2(FTB_SETS)
- FTB_WAYS, 4, associativity (power of 2); WAY_W = log2(FTB_WAYS)
- FIX_BURST_MAX, 3, consecutive fix grants allowed while commit is waiting

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_fix_vld  in  1  predecode-fix update valid
- i_fix_info  in  BPupdateInfo_t  fix update payload
- o_fix_rdy  out  1  fix update accepted when vld&rdy
- i_cmt_vld  in  1  commit update valid
- i_cmt_info  in  BPupdateInfo_t  commit update payload
- o_cmt_rdy  out  1  commit update accepted when vld&rdy
- o_rd_req  out  1  FTB read request (shared port)
- o_rd_idx  out  IDX_W  read set index
- i_rd_gnt  in  1  read granted this cycle (low when predictor uses port)
- i_rd_entries  in  FTB_WAYS x ftbEntry_t  set contents, valid the cycle after grant
- o_wr_req  out  1  FTB write request
- o_wr_idx  out  IDX_W  write set index
- o_wr_way  out  WAY_W  write way
- o_wr_entry  out  ftbEntry_t  entry to write
- i_wr_gnt  in  1  write accepted this cycle
- o_busy  out  1  update in flight (state != IDLE)

Behaviour:
- Reset: state=IDLE; all outputs 0, except o_fix_rdy and o_cmt_rdy = 1. Victim pointer = 0; fix burst counter = 0.
- Address split: idx = startAddr[IDX_W:1]; tag = startAddr[IDX_W+FTB_TAG_WIDTH : IDX_W+1].
- Ready rule: o_fix_rdy / o_cmt_rdy are high only in IDLE and only for the requester that wins arbitration that cycle. At most one handshake per cycle.
- Arbitration in IDLE:
  - Fix wins over commit.
  - Exception: when the burst counter == FIX_BURST_MAX and i_cmt_vld=1, commit wins.
  - Burst counter increments on a fix grant while i_cmt_vld=1, clears on any commit grant, and saturates.
- FSM:
  - IDLE: on a handshake, latch info, idx and tag; go to RD.
  - RD: o_rd_req=1, o_rd_idx=idx. Stay in RD until i_rd_gnt=1, then go to RSP.
  - RSP: sample i_rd_entries and compute the merged entry.
    - hit = any way with vld && tag match; the lowest hit way wins.
    - go to WR.
  - WR: o_wr_req=1 with registered idx, way and entry. Stay in WR until i_wr_gnt=1, then go to IDLE.
- Merge on hit:
  - entry = {tag, vld=1, info}, using the hit way.
  - counter = saturating update of the stored counter: +1 if info.counter[1]=1, -1 otherwise, clamped to 0..3.
- Allocate on miss:
  - entry = {tag, vld=1, info} with counter = info.counter as supplied.
  - way = lowest-index invalid way. If none is invalid, way = victim pointer, and the pointer then increments mod FTB_WAYS.
  - The pointer advances only on a no-invalid-way allocation, at WR completion.
- Latency: minimum 4 cycles from handshake to write grant (IDLE, RD, RSP, WR, with both grants immediate). Next handshake is possible on the cycle after the write grant.
- Only one update is in flight, so there are no same-set hazards inside the block.
- Input stability: payloads need be stable only during the handshake cycle.
- Simultaneous vld on both requesters: only the winner sees rdy; the loser holds.
- Reset mid-operation: returns to IDLE immediately. The in-flight update is dropped with no write issued; the requester is not re-notified.
- The write port never issues a partial write: o_wr_* hold stable while o_wr_req=1 && !i_wr_gnt.

Decomposition:
- Add to the frontend shared package:
  - ftbUpdState_t enum {IDLE, RD, RSP, WR}
  - functions ftbIdx(pc), ftbTag(pc), satCnt2(cnt, up) in ftbFuncs
- Sub-module ftb_victim_sel: combinational invalid-way scan plus the registered round-robin pointer. Inputs are the way valid vector and an advance strobe; outputs are the way and an all-valid flag.

Test Plan:
- Single commit miss, empty set, startAddr=0x1000, counter=2'b10, grants immediate -> rd at cycle 1, write at cycle 3 with way=0, vld=1, counter=2; o_busy low at cycle 4.
- Hit with stored counter=3, update counter[1]=1 -> written counter=3 (saturate). Stored 0 with counter[1]=0 -> written 0. Stored 1 with counter[1]=1 -> written 2.
- Full set (all 4 ways valid, no match), 5 consecutive misses to the same set -> ways 0,1,2,3,0 chosen.
- Fix and commit both continuously valid, FIX_BURST_MAX=3 -> grant order fix, fix, fix, commit, fix, ...
- i_rd_gnt held low 5 cycles -> o_rd_req held, no rdy asserted; write occurs 5 cycles later than baseline with unchanged entry.
- rst asserted in WR with i_wr_gnt=0 -> o_wr_req=0 in the same cycle (async). After release, state IDLE and both rdy=1.

Source files
------------

// File: rtl/ftb_update_ctrl_pkg.sv
// Shared frontend types, sizes and helpers for the FTB update path.
package ftb_update_ctrl_pkg;

    localparam int unsigned FTB_SETS      = 512;
    localparam int unsigned FTB_WAYS      = 4;
    localparam int unsigned FIX_BURST_MAX = 3;
    localparam int unsigned IDX_W         = $clog2(FTB_SETS);
    localparam int unsigned WAY_W         = $clog2(FTB_WAYS);
    localparam int unsigned FTB_TAG_WIDTH = 20;
    localparam int unsigned PC_W          = 32;
    localparam int unsigned BURST_W       = $clog2(FIX_BURST_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_RSP, ST_WR} ftbUpdState_t;

    typedef struct packed {
        logic [PC_W-1:0] startAddr;
        logic [PC_W-1:0] target;
        logic [1:0]      counter;
    } BPupdateInfo_t;

    typedef struct packed {
        logic                     vld;
        logic [FTB_TAG_WIDTH-1:0] tag;
        logic [PC_W-1:0]          target;
        logic [1:0]               counter;
    } ftbEntry_t;

    // ftbFuncs: address split and 2-bit saturating counter
    function automatic logic [IDX_W-1:0] ftbIdx(input logic [PC_W-1:0] pc);
        return pc[IDX_W:1];
    endfunction

    function automatic logic [FTB_TAG_WIDTH-1:0] ftbTag(input logic [PC_W-1:0] pc);
        return pc[IDX_W+FTB_TAG_WIDTH:IDX_W+1];
    endfunction

    function automatic logic [1:0] satCnt2(input logic [1:0] cnt, input logic up);
        if (up) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
        return (cnt == 2'd0) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/ftb_update_ctrl_if.sv
// Bundle of update requester handshakes plus FTB SRAM read/write ports.
interface ftb_update_ctrl_if;
    import ftb_update_ctrl_pkg::*;

    logic                        fix_vld;
    BPupdateInfo_t               fix_info;
    logic                        fix_rdy;
    logic                        cmt_vld;
    BPupdateInfo_t               cmt_info;
    logic                        cmt_rdy;
    logic                        rd_req;
    logic [IDX_W-1:0]            rd_idx;
    logic                        rd_gnt;
    ftbEntry_t [FTB_WAYS-1:0]    rd_entries;
    logic                        wr_req;
    logic [IDX_W-1:0]            wr_idx;
    logic [WAY_W-1:0]            wr_way;
    ftbEntry_t                   wr_entry;
    logic                        wr_gnt;
    logic                        busy;

    modport master (
        output fix_vld, fix_info, cmt_vld, cmt_info, rd_gnt, rd_entries, wr_gnt,
        input  fix_rdy, cmt_rdy, rd_req, rd_idx, wr_req, wr_idx, wr_way, wr_entry, busy
    );

    modport slave (
        input  fix_vld, fix_info, cmt_vld, cmt_info, rd_gnt, rd_entries, wr_gnt,
        output fix_rdy, cmt_rdy, rd_req, rd_idx, wr_req, wr_idx, wr_way, wr_entry, busy
    );

endinterface

// File: rtl/ftb_update_ctrl_victim_sel.sv
// Allocation way picker: lowest invalid way, else a round-robin victim pointer.
module ftb_update_ctrl_victim_sel
    import ftb_update_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [FTB_WAYS-1:0] vld,
    input  logic                adv,
    output logic [WAY_W-1:0]    way_c,
    output logic                all_vld_c
);

    logic [WAY_W-1:0] ptr_q;

    always_comb begin
        way_c     = ptr_q;
        all_vld_c = &vld;
        for (int i = FTB_WAYS - 1; i >= 0; i--) begin
            if (!vld[i]) way_c = WAY_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ptr_q <= '0;
        else if (adv) ptr_q <= ptr_q + WAY_W'(1);
    end

endmodule

// File: rtl/ftb_update_ctrl.sv
// Arbitrates fix/commit updates and runs one read-modify-write per update on the FTB.
module ftb_update_ctrl
    import ftb_update_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ftb_update_ctrl_if.slave   bus
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] RD   = 2'(ST_RD);
    localparam logic [1:0] RSP  = 2'(ST_RSP);
    localparam logic [1:0] WR   = 2'(ST_WR);

    logic [1:0]               state, state_nxt;
    logic [BURST_W-1:0]       burst_q;
    logic [IDX_W-1:0]         idx_q;
    logic [FTB_TAG_WIDTH-1:0] tag_q;
    logic [PC_W-1:0]          tgt_q;
    logic [1:0]               cnt_q;
    logic [WAY_W-1:0]         way_q;
    ftbEntry_t                entry_q;
    logic                     use_ptr_q;

    logic                     idle_c, cmt_prio_c, fix_fire_c, cmt_fire_c;
    BPupdateInfo_t            sel_info_c;
    logic [FTB_WAYS-1:0]      way_vld_c;
    logic                     hit_c;
    logic [WAY_W-1:0]         hit_way_c;
    logic [WAY_W-1:0]         victim_way_c;
    logic                     all_vld_c;
    ftbEntry_t                merged_c;
    logic                     unused_c;

    // Fix normally wins; commit is forced through once fix has used its burst allowance.
    assign idle_c      = (state == IDLE);
    assign cmt_prio_c  = (burst_q == BURST_W'(FIX_BURST_MAX));
    assign bus.fix_rdy = idle_c && !(cmt_prio_c && bus.cmt_vld);
    assign bus.cmt_rdy = idle_c && (cmt_prio_c || !bus.fix_vld);
    assign fix_fire_c  = bus.fix_vld && bus.fix_rdy;
    assign cmt_fire_c  = bus.cmt_vld && bus.cmt_rdy;
    assign sel_info_c  = cmt_fire_c ? bus.cmt_info : bus.fix_info;
    assign unused_c    = ^{sel_info_c.startAddr[PC_W-1:IDX_W+FTB_TAG_WIDTH+1],
                           sel_info_c.startAddr[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fix_fire_c || cmt_fire_c) state_nxt = RD;
            RD:      if (bus.rd_gnt) state_nxt = RSP;
            RSP:     state_nxt = WR;
            WR:      if (bus.wr_gnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tag lookup over the returned set; the descending scan leaves the lowest hit way.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        way_vld_c = '0;
        for (int i = FTB_WAYS - 1; i >= 0; i--) begin
            way_vld_c[i] = bus.rd_entries[i].vld;
            if (bus.rd_entries[i].vld && (bus.rd_entries[i].tag == tag_q)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(i);
            end
        end
        merged_c.vld     = 1'b1;
        merged_c.tag     = tag_q;
        merged_c.target  = tgt_q;
        merged_c.counter = hit_c ? satCnt2(bus.rd_entries[hit_way_c].counter, cnt_q[1]) : cnt_q;
    end

    ftb_update_ctrl_victim_sel u_victim_sel (
        .clk       (clk),
        .rst       (rst),
        .vld       (way_vld_c),
        .adv       ((state == WR) && bus.wr_gnt && use_ptr_q),
        .way_c     (victim_way_c),
        .all_vld_c (all_vld_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_q   <= '0;
            idx_q     <= '0;
            tag_q     <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            way_q     <= '0;
            entry_q   <= '0;
            use_ptr_q <= 1'b0;
        end else begin
            if (cmt_fire_c) burst_q <= '0;
            else if (fix_fire_c && bus.cmt_vld && !cmt_prio_c) burst_q <= burst_q + BURST_W'(1);
            if (fix_fire_c || cmt_fire_c) begin
                idx_q <= ftbIdx(sel_info_c.startAddr);
                tag_q <= ftbTag(sel_info_c.startAddr);
                tgt_q <= sel_info_c.target;
                cnt_q <= sel_info_c.counter;
            end
            if (state == RSP) begin
                way_q     <= hit_c ? hit_way_c : victim_way_c;
                entry_q   <= merged_c;
                use_ptr_q <= !hit_c && all_vld_c;
            end
        end
    end

    assign bus.rd_req   = (state == RD);
    assign bus.rd_idx   = idx_q;
    assign bus.wr_req   = (state == WR);
    assign bus.wr_idx   = idx_q;
    assign bus.wr_way   = way_q;
    assign bus.wr_entry = entry_q;
    assign bus.busy     = !idle_c;

endmodule

// File: tb/tb_ftb_update_ctrl.sv
// Directed bench for ftb_update_ctrl with hand-computed expected writes.
module tb_ftb_update_ctrl;
    import ftb_update_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ftb_update_ctrl_if bus ();

    ftb_update_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_way(input int w, input logic v, input logic [19:0] t, input logic [1:0] c);
        bus.rd_entries[w].vld     = v;
        bus.rd_entries[w].tag     = t;
        bus.rd_entries[w].target  = 32'hDEAD_0000;
        bus.rd_entries[w].counter = c;
    endtask

    // Issues one update from IDLE (#1 after posedge) and checks every stage of it.
    task automatic do_update(input string nm, input logic is_cmt, input logic [31:0] addr,
                             input logic [1:0] cnt, input int rd_dly,
                             input logic [8:0] exp_idx, input logic [19:0] exp_tag,
                             input logic [1:0] exp_way, input logic [1:0] exp_cnt,
                             input int exp_lat);
        BPupdateInfo_t inf;
        ftbEntry_t     exp_e;
        int            lat;
        inf.startAddr = addr;
        inf.target    = addr + 32'h40;
        inf.counter   = cnt;
        exp_e.vld     = 1'b1;
        exp_e.tag     = exp_tag;
        exp_e.target  = addr + 32'h40;
        exp_e.counter = exp_cnt;
        if (is_cmt) begin bus.cmt_vld = 1'b1; bus.cmt_info = inf; end
        else        begin bus.fix_vld = 1'b1; bus.fix_info = inf; end
        #1;
        check_eq({nm, ".rdy"}, 64'(is_cmt ? bus.cmt_rdy : bus.fix_rdy), 64'(1));
        @(posedge clk); #1;
        lat = 1;
        bus.fix_vld = 1'b0;
        bus.cmt_vld = 1'b0;
        for (int k = 0; k < rd_dly; k++) begin
            check_eq({nm, ".rd_hold"}, 64'(bus.rd_req), 64'(1));
            check_eq({nm, ".rdy_busy"}, 64'({bus.fix_rdy, bus.cmt_rdy}), 64'(0));
            @(posedge clk); #1;
            lat++;
        end
        check_eq({nm, ".rd_req"}, 64'(bus.rd_req), 64'(1));
        check_eq({nm, ".rd_idx"}, 64'(bus.rd_idx), 64'(exp_idx));
        bus.rd_gnt = 1'b1;
        @(posedge clk); #1;
        bus.rd_gnt = 1'b0;
        lat++;
        @(posedge clk); #1;
        lat++;
        check_eq({nm, ".wr_req"}, 64'(bus.wr_req), 64'(1));
        check_eq({nm, ".wr_idx"}, 64'(bus.wr_idx), 64'(exp_idx));
        check_eq({nm, ".wr_way"}, 64'(bus.wr_way), 64'(exp_way));
        check_eq({nm, ".wr_entry"}, 64'(bus.wr_entry), 64'(exp_e));
        check_eq({nm, ".latency"}, 64'(lat), 64'(exp_lat));
        bus.wr_gnt = 1'b1;
        @(posedge clk); #1;
        bus.wr_gnt = 1'b0;
        check_eq({nm, ".busy_done"}, 64'(bus.busy), 64'(0));
    endtask

    logic [1:0] exp_ways [5];
    logic       order    [5];
    logic       exp_ord  [5];
    int         ng;
    ftbEntry_t  held;

    initial begin
        rst          = 1'b1;
        bus.fix_vld  = 1'b0;
        bus.cmt_vld  = 1'b0;
        bus.fix_info = '0;
        bus.cmt_info = '0;
        bus.rd_gnt   = 1'b0;
        bus.wr_gnt   = 1'b0;
        bus.rd_entries = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.fix_rdy", 64'(bus.fix_rdy), 64'(1));
        check_eq("reset.cmt_rdy", 64'(bus.cmt_rdy), 64'(1));
        check_eq("reset.outs", 64'({bus.busy, bus.rd_req, bus.wr_req}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // 0x1000: idx 0, tag 4; empty set allocates way 0
        do_update("cmt_miss", 1'b1, 32'h0000_1000, 2'b10, 0, 9'h000, 20'h4, 2'd0, 2'd2, 3);

        // 0x1234: idx 0x11A, tag 4
        set_way(0, 1'b1, 20'h5, 2'd0);
        set_way(1, 1'b1, 20'h4, 2'd3);
        do_update("hit_sat3", 1'b0, 32'h0000_1234, 2'b10, 0, 9'h11A, 20'h4, 2'd1, 2'd3, 3);
        set_way(1, 1'b1, 20'h4, 2'd0);
        do_update("hit_sat0", 1'b0, 32'h0000_1234, 2'b01, 0, 9'h11A, 20'h4, 2'd1, 2'd0, 3);
        set_way(1, 1'b1, 20'h4, 2'd1);
        do_update("hit_inc", 1'b1, 32'h0000_1234, 2'b11, 0, 9'h11A, 20'h4, 2'd1, 2'd2, 3);
        set_way(0, 1'b0, 20'h4, 2'd3);
        set_way(1, 1'b0, 20'h4, 2'd3);
        set_way(2, 1'b1, 20'h4, 2'd2);
        set_way(3, 1'b1, 20'h4, 2'd0);
        do_update("hit_lowest", 1'b0, 32'h0000_1234, 2'b00, 0, 9'h11A, 20'h4, 2'd2, 2'd1, 3);
        set_way(0, 1'b1, 20'h5, 2'd0);
        set_way(1, 1'b0, 20'h4, 2'd0);
        set_way(2, 1'b1, 20'h6, 2'd0);
        set_way(3, 1'b1, 20'h7, 2'd0);
        do_update("miss_hole", 1'b0, 32'h0000_1234, 2'b01, 0, 9'h11A, 20'h4, 2'd1, 2'd1, 3);

        // Full set without a match walks the victim pointer
        set_way(0, 1'b1, 20'h5, 2'd0);
        set_way(1, 1'b1, 20'h6, 2'd0);
        set_way(2, 1'b1, 20'h7, 2'd0);
        set_way(3, 1'b1, 20'h9, 2'd0);
        exp_ways = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++)
            do_update($sformatf("victim%0d", i), 1'b1, 32'h0000_1234, 2'b11, 0,
                      9'h11A, 20'h4, exp_ways[i], 2'd3, 3);

        // Delayed read grant: write lands 5 cycles later, same entry
        bus.rd_entries = '0;
        do_update("rd_stall", 1'b0, 32'h0000_1000, 2'b01, 5, 9'h000, 20'h4, 2'd0, 2'd1, 8);

        // Both requesters continuously valid, grants immediate
        bus.fix_info = '{startAddr: 32'h0000_3000, target: 32'h0, counter: 2'b10};
        bus.cmt_info = '{startAddr: 32'h0000_5000, target: 32'h0, counter: 2'b01};
        bus.fix_vld = 1'b1;
        bus.cmt_vld = 1'b1;
        bus.rd_gnt  = 1'b1;
        bus.wr_gnt  = 1'b1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            @(negedge clk);
            if (bus.fix_vld && bus.fix_rdy)      begin order[ng] = 1'b0; ng++; end
            else if (bus.cmt_vld && bus.cmt_rdy) begin order[ng] = 1'b1; ng++; end
        end
        @(posedge clk); #1;
        bus.fix_vld = 1'b0;
        bus.cmt_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.rd_gnt = 1'b0;
        bus.wr_gnt = 1'b0;
        check_eq("arb.grants", 64'(ng), 64'(5));
        exp_ord = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5 && i < ng; i++)
            check_eq($sformatf("arb.order%0d", i), 64'(order[i]), 64'(exp_ord[i]));
        check_eq("arb.idle", 64'(bus.busy), 64'(0));

        // Reset while stalled in WR: 0x2000 -> idx 0, tag 8
        bus.fix_info = '{startAddr: 32'h0000_2000, target: 32'h0000_2040, counter: 2'b11};
        bus.fix_vld  = 1'b1;
        @(posedge clk); #1;
        bus.fix_vld = 1'b0;
        bus.rd_gnt  = 1'b1;
        @(posedge clk); #1;
        bus.rd_gnt = 1'b0;
        @(posedge clk); #1;
        check_eq("rstwr.wr_req", 64'(bus.wr_req), 64'(1));
        held = bus.wr_entry;
        check_eq("rstwr.entry", 64'(held), 64'({1'b1, 20'h8, 32'h0000_2040, 2'b11}));
        @(posedge clk); #1;
        check_eq("rstwr.stable", 64'({bus.wr_req, bus.wr_way, bus.wr_entry}),
                 64'({1'b1, 2'd0, held}));
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstwr.async_wr", 64'(bus.wr_req), 64'(0));
        check_eq("rstwr.async_busy", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rstwr.rdy", 64'({bus.fix_rdy, bus.cmt_rdy}), 64'(2'b11));
        check_eq("rstwr.outs", 64'({bus.busy, bus.rd_req, bus.wr_req}), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
